// File: rtl/rv32i_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32i pipeline: RAW interlock via a 3-entry rd scoreboard,
// branch/jump flushes and data-memory wait freeze. Define HAZARD_PERF_CNT_EN to add stall/flush counters.
module rv32i_hazard_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [31:0] dec_instr_i,
  input  logic        br_taken_i,
  input  logic        dmem_ready_i,
  output logic        stall_dec_o,
  output logic        stall_exec_o,
  output logic        flush_dec_o,
  output logic        flush_exec_o,
  output logic        fetch_nop_o,
  output logic [4:0]  rd_add_o,
  output logic        reg_we_o,
  output logic [1:0]  hazard_state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_MWAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic       we;
    logic [4:0] rd;
  } sb_entry_t;

  // Writes to x0 are never tracked, so x0 can never raise a hazard.
  function automatic sb_entry_t dest_entry(input logic [6:0] opc, input logic [4:0] rd);
    sb_entry_t e;
    e.we = (opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP})
           && (rd != 5'd0);
    e.rd = e.we ? rd : 5'd0;
    return e;
  endfunction

  localparam sb_entry_t BUBBLE = dest_entry(NOP_INSTR[6:0], NOP_INSTR[11:7]);

  logic [6:0] opc_w;
  logic [4:0] rs1_w, rs2_w;
  logic       rs1_used_w, rs2_used_w, is_jump_w, raw_w;
  sb_entry_t  dec_entry_w;
  logic       unused_w;

  assign opc_w       = dec_instr_i[6:0];
  assign rs1_w       = dec_instr_i[19:15];
  assign rs2_w       = dec_instr_i[24:20];
  assign rs1_used_w  = opc_w inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
  assign rs2_used_w  = opc_w inside {OPC_BRANCH, OPC_STORE, OPC_OP};
  assign is_jump_w   = (opc_w == OPC_JAL) || (opc_w == OPC_JALR);
  assign dec_entry_w = dest_entry(opc_w, dec_instr_i[11:7]);
  assign unused_w    = ^{dec_instr_i[31:25], dec_instr_i[14:12]};

  // Index 0 = EXEC, 1 = MEM, 2 = WB.
  sb_entry_t sb_q [3];
  sb_entry_t sb_d [3];
  state_e    state_q, state_d;

  // The WB entry is included: the register file does not forward a write to a same-cycle read.
  always_comb begin
    raw_w = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sb_q[i].we && (sb_q[i].rd != 5'd0) &&
          ((rs1_used_w && (rs1_w == sb_q[i].rd)) || (rs2_used_w && (rs2_w == sb_q[i].rd))))
        raw_w = 1'b1;
    end
  end

  logic stall_dec_w, stall_exec_w, flush_dec_w, flush_exec_w, fetch_nop_w;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    state_d      = ST_RUN;
    stall_dec_w  = 1'b0;
    stall_exec_w = 1'b0;
    flush_dec_w  = 1'b0;
    flush_exec_w = 1'b0;
    fetch_nop_w  = 1'b0;
    if (!dmem_ready_i) begin
      state_d      = ST_MWAIT;
      stall_dec_w  = 1'b1;
      stall_exec_w = 1'b1;
    end else if (br_taken_i) begin
      flush_dec_w  = 1'b1;
      flush_exec_w = 1'b1;
    end else if (raw_w) begin
      state_d      = ST_STALL;
      stall_dec_w  = 1'b1;
      flush_exec_w = 1'b1;
    end else if (is_jump_w) begin
      fetch_nop_w  = 1'b1;
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (!stall_exec_w) begin
      sb_d[2] = sb_q[1];
      sb_d[1] = sb_q[0];
      sb_d[0] = flush_exec_w ? BUBBLE : dec_entry_w;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_RUN;
      sb_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
    end
  end

  // Controls are held low while reset is asserted, whatever DEC or the memory presents.
  assign stall_dec_o    = resetn_i & stall_dec_w;
  assign stall_exec_o   = resetn_i & stall_exec_w;
  assign flush_dec_o    = resetn_i & flush_dec_w;
  assign flush_exec_o   = resetn_i & flush_exec_w;
  assign fetch_nop_o    = resetn_i & fetch_nop_w;
  assign rd_add_o       = sb_q[2].rd;
  assign reg_we_o       = sb_q[2].we;
  assign hazard_state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_dec_w};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_dec_w};
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Directed self-checking bench for rv32i_hazard_ctrl: interlock, x0, branch, jump, memory wait, reset.
module tb_rv32i_hazard_ctrl;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] ADDI_X5_1  = 32'h0010_0293;
  localparam logic [31:0] ADD_X6_X5  = 32'h0052_8333;
  localparam logic [31:0] ADDI_X0_7  = 32'h0070_0013;
  localparam logic [31:0] ADD_X6_X0  = 32'h0000_0333;
  localparam logic [31:0] BEQ_P8     = 32'h0000_0463;
  localparam logic [31:0] JAL_X1_16  = 32'h0100_00EF;
  localparam logic [31:0] JALR_X1_X5 = 32'h0002_80E7;
  localparam logic [31:0] LW_X7      = 32'h0000_2383;

  // {stall_dec, stall_exec, flush_dec, flush_exec, fetch_nop}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_RAW  = 5'b10010;
  localparam logic [4:0] C_BR   = 5'b00110;
  localparam logic [4:0] C_MW   = 5'b11000;
  localparam logic [4:0] C_JMP  = 5'b00001;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic [31:0] dec_instr_i;
  logic        br_taken_i;
  logic        dmem_ready_i;
  logic        stall_dec_o, stall_exec_o, flush_dec_o, flush_exec_o, fetch_nop_o;
  logic [4:0]  rd_add_o;
  logic        reg_we_o;
  logic [1:0]  hazard_state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  logic [4:0] ctl_w;
  logic [5:0] wb_w;
  assign ctl_w = {stall_dec_o, stall_exec_o, flush_dec_o, flush_exec_o, fetch_nop_o};
  assign wb_w  = {reg_we_o, rd_add_o};

  always #5 clk_i = ~clk_i;

  rv32i_hazard_ctrl dut (
    .clk_i          (clk_i),
    .resetn_i       (resetn_i),
    .dec_instr_i    (dec_instr_i),
    .br_taken_i     (br_taken_i),
    .dmem_ready_i   (dmem_ready_i),
    .stall_dec_o    (stall_dec_o),
    .stall_exec_o   (stall_exec_o),
    .flush_dec_o    (flush_dec_o),
    .flush_exec_o   (flush_exec_o),
    .fetch_nop_o    (fetch_nop_o),
    .rd_add_o       (rd_add_o),
    .reg_we_o       (reg_we_o),
    .hazard_state_o (hazard_state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  // One pipeline cycle: inputs change just after the rising edge, outputs are observed at the falling edge.
  task automatic cyc(input logic [31:0] instr, input logic br, input logic rdy);
    @(posedge clk_i);
    #1;
    dec_instr_i  = instr;
    br_taken_i   = br;
    dmem_ready_i = rdy;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(NOP, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    resetn_i     = 1'b0;
    dec_instr_i  = NOP;
    br_taken_i   = 1'b0;
    dmem_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    total++; if (ctl_w !== C_NONE) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl_w, C_NONE); end
    total++; if (wb_w !== 6'd0) begin bad++; $display("FAIL reset_wb got=%h exp=00", wb_w); end
    total++; if (hazard_state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", hazard_state_o); end
`ifdef HAZARD_PERF_CNT_EN
    total++; if ({stall_cnt_o, flush_cnt_o} !== 64'd0) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cnt_o, flush_cnt_o); end
`endif
    resetn_i = 1'b1;
    cyc(NOP, 1'b0, 1'b1);
    total++; if ({ctl_w, wb_w, hazard_state_o} !== 13'd0) begin bad++; $display("FAIL post_reset got=%b/%h/%0d exp=0", ctl_w, wb_w, hazard_state_o); end
  endtask

  task automatic test_raw();
    idle(3);
    cyc(ADDI_X5_1, 1'b0, 1'b1);
    total++; if (ctl_w !== C_NONE) begin bad++; $display("FAIL raw_producer got=%b exp=%b", ctl_w, C_NONE); end
    for (int i = 0; i < 3; i++) begin
      cyc(ADD_X6_X5, 1'b0, 1'b1);
      total++; if (ctl_w !== C_RAW) begin bad++; $display("FAIL raw_stall%0d got=%b exp=%b", i, ctl_w, C_RAW); end
      if (i == 1) begin
        total++; if (hazard_state_o !== 2'd1) begin bad++; $display("FAIL raw_state got=%0d exp=1", hazard_state_o); end
      end
      if (i == 2) begin
        total++; if (wb_w !== {1'b1, 5'd5}) begin bad++; $display("FAIL raw_wb_x5 got=%h exp=%h", wb_w, {1'b1, 5'd5}); end
      end
    end
    cyc(ADD_X6_X5, 1'b0, 1'b1);
    total++; if (ctl_w !== C_NONE) begin bad++; $display("FAIL raw_release got=%b exp=%b", ctl_w, C_NONE); end
    total++; if (hazard_state_o !== 2'd1) begin bad++; $display("FAIL raw_release_state got=%0d exp=1", hazard_state_o); end
    idle(3);
    total++; if (wb_w !== {1'b1, 5'd6}) begin bad++; $display("FAIL raw_wb_x6 got=%h exp=%h", wb_w, {1'b1, 5'd6}); end
  endtask

  task automatic test_x0();
    idle(3);
    cyc(ADDI_X0_7, 1'b0, 1'b1);
    cyc(ADD_X6_X0, 1'b0, 1'b1);
    total++; if (ctl_w !== C_NONE) begin bad++; $display("FAIL x0_no_stall got=%b exp=%b", ctl_w, C_NONE); end
    idle(2);
    total++; if (reg_we_o !== 1'b0) begin bad++; $display("FAIL x0_no_write got=%b exp=0", reg_we_o); end
    idle(1);
    total++; if (wb_w !== {1'b1, 5'd6}) begin bad++; $display("FAIL x0_wb_x6 got=%h exp=%h", wb_w, {1'b1, 5'd6}); end
  endtask

  task automatic test_branch();
    idle(3);
    cyc(ADDI_X5_1, 1'b0, 1'b1);
    cyc(BEQ_P8, 1'b0, 1'b1);
    total++; if (ctl_w !== C_NONE) begin bad++; $display("FAIL br_decode got=%b exp=%b", ctl_w, C_NONE); end
    // Wrong-path instruction in DEC depends on x5, but the taken branch wins.
    cyc(ADD_X6_X5, 1'b1, 1'b1);
    total++; if (ctl_w !== C_BR) begin bad++; $display("FAIL br_flush got=%b exp=%b", ctl_w, C_BR); end
    cyc(NOP, 1'b0, 1'b1);
    total++; if (ctl_w !== C_NONE) begin bad++; $display("FAIL br_after got=%b exp=%b", ctl_w, C_NONE); end
    total++; if (wb_w !== {1'b1, 5'd5}) begin bad++; $display("FAIL br_wb_x5 got=%h exp=%h", wb_w, {1'b1, 5'd5}); end
    total++; if (hazard_state_o !== 2'd0) begin bad++; $display("FAIL br_state got=%0d exp=0", hazard_state_o); end
    for (int i = 0; i < 3; i++) begin
      cyc(NOP, 1'b0, 1'b1);
      total++; if (reg_we_o !== 1'b0) begin bad++; $display("FAIL br_no_write%0d got=%b exp=0", i, reg_we_o); end
    end
  endtask

  task automatic test_jal();
    idle(3);
    cyc(JAL_X1_16, 1'b0, 1'b1);
    total++; if (ctl_w !== C_JMP) begin bad++; $display("FAIL jal_nop got=%b exp=%b", ctl_w, C_JMP); end
    cyc(NOP, 1'b0, 1'b1);
    total++; if (ctl_w !== C_NONE) begin bad++; $display("FAIL jal_after got=%b exp=%b", ctl_w, C_NONE); end
    cyc(NOP, 1'b0, 1'b1);
    total++; if (reg_we_o !== 1'b0) begin bad++; $display("FAIL jal_early_we got=%b exp=0", reg_we_o); end
    cyc(NOP, 1'b0, 1'b1);
    total++; if (wb_w !== {1'b1, 5'd1}) begin bad++; $display("FAIL jal_wb_x1 got=%h exp=%h", wb_w, {1'b1, 5'd1}); end
  endtask

  task automatic test_mwait();
    idle(3);
    cyc(ADDI_X5_1, 1'b0, 1'b1);
    cyc(NOP, 1'b0, 1'b1);
    cyc(LW_X7, 1'b0, 1'b1);
    total++; if (ctl_w !== C_NONE) begin bad++; $display("FAIL mw_lw got=%b exp=%b", ctl_w, C_NONE); end
    // Last frozen cycle also carries a taken branch: freeze must still win.
    for (int i = 0; i < 4; i++) begin
      cyc(NOP, (i == 3), 1'b0);
      total++; if (ctl_w !== C_MW) begin bad++; $display("FAIL mw_ctl%0d got=%b exp=%b", i, ctl_w, C_MW); end
      total++; if (wb_w !== {1'b1, 5'd5}) begin bad++; $display("FAIL mw_frozen%0d got=%h exp=%h", i, wb_w, {1'b1, 5'd5}); end
      if (i > 0) begin
        total++; if (hazard_state_o !== 2'd2) begin bad++; $display("FAIL mw_state%0d got=%0d exp=2", i, hazard_state_o); end
      end
    end
    cyc(NOP, 1'b1, 1'b1);
    total++; if (ctl_w !== C_BR) begin bad++; $display("FAIL mw_br_resume got=%b exp=%b", ctl_w, C_BR); end
    cyc(NOP, 1'b0, 1'b1);
    total++; if (hazard_state_o !== 2'd0) begin bad++; $display("FAIL mw_run got=%0d exp=0", hazard_state_o); end
    cyc(NOP, 1'b0, 1'b1);
    total++; if (wb_w !== {1'b1, 5'd7}) begin bad++; $display("FAIL mw_wb_x7 got=%h exp=%h", wb_w, {1'b1, 5'd7}); end
  endtask

  task automatic test_back_to_back();
    idle(3);
    cyc(ADDI_X5_1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(JALR_X1_X5, 1'b0, 1'b1);
      total++; if (ctl_w !== C_RAW) begin bad++; $display("FAIL jalr_stall%0d got=%b exp=%b", i, ctl_w, C_RAW); end
    end
    cyc(JALR_X1_X5, 1'b0, 1'b1);
    total++; if (ctl_w !== C_JMP) begin bad++; $display("FAIL jalr_nop got=%b exp=%b", ctl_w, C_JMP); end
    idle(3);
    total++; if (wb_w !== {1'b1, 5'd1}) begin bad++; $display("FAIL jalr_wb_x1 got=%h exp=%h", wb_w, {1'b1, 5'd1}); end
  endtask

  task automatic test_reset_mid_stall();
    idle(3);
    cyc(ADDI_X5_1, 1'b0, 1'b1);
    cyc(ADD_X6_X5, 1'b0, 1'b1);
    cyc(ADD_X6_X5, 1'b0, 1'b1);
    total++; if ({ctl_w, hazard_state_o} !== {C_RAW, 2'd1}) begin bad++; $display("FAIL rst_pre got=%b/%0d exp=%b/1", ctl_w, hazard_state_o, C_RAW); end
    #2 resetn_i = 1'b0;
    #1;
    total++; if ({ctl_w, wb_w, hazard_state_o} !== 13'd0) begin bad++; $display("FAIL rst_async got=%b/%h/%0d exp=0", ctl_w, wb_w, hazard_state_o); end
    @(negedge clk_i);
    resetn_i = 1'b1;
    #1;
    total++; if ({ctl_w, hazard_state_o} !== 7'd0) begin bad++; $display("FAIL rst_release got=%b/%0d exp=0", ctl_w, hazard_state_o); end
    cyc(ADD_X6_X5, 1'b0, 1'b1);
    total++; if ({ctl_w, wb_w, hazard_state_o} !== 13'd0) begin bad++; $display("FAIL rst_after got=%b/%h/%0d exp=0", ctl_w, wb_w, hazard_state_o); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_x0();
    test_branch();
    test_jal();
    test_mwait();
    test_back_to_back();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_hazard_ctrl.md
# rv32i_hazard_ctrl

Pipeline hazard controller for the 5-stage RV32i core (FETCH, DEC, EXEC, MEM, WB). It tracks destination registers in flight in a 3-entry scoreboard and drives the datapath's stall, flush and fetch-NOP controls. It resolves RAW hazards by interlock, because the core has no bypass network, and handles control hazards and data-memory wait states. It also supplies the WB-stage register-file write address and write enable.

## Interface
Parameters:
- NOP_INSTR, 32'h0000_0013, instruction value that a flushed stage is treated as (addi x0,x0,0)

Ports:
- Reset: resetn_i, asynchronous, active-low; clock: clk_i.
- clk_i  in  1  clock
- resetn_i  in  1  asynchronous active-low reset
- dec_instr_i  in  32  instruction currently held in the DEC register
- br_taken_i  in  1  conditional branch in EXEC resolved taken, combinational from ALU flags
- dmem_ready_i  in  1  data memory ready; 0 freezes EXEC/MEM/WB
- stall_dec_o  out  1  hold PC and DEC register
- stall_exec_o  out  1  hold EXEC/MEM/WB registers
- flush_dec_o  out  1  load NOP into DEC
- flush_exec_o  out  1  load bubble into EXEC
- fetch_nop_o  out  1  substitute NOP for the fetched word
- rd_add_o  out  5  WB-stage destination register
- reg_we_o  out  1  WB-stage register-file write enable
- hazard_state_o  out  2  FSM state, for debug

## Operation
- Opcode decode on dec_instr_i[6:0]:
  - Writes rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - Reads rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Reads rs2: BRANCH, STORE, OP.
- Scoreboard: three entries {we, rd[4:0]} for EXEC, MEM and WB.
  - An entry with rd=x0 is stored with we=0.
  - rd_add_o/reg_we_o are the WB entry.
- RAW hazard (raw_w): a used rs1 or rs2 is nonzero and equals rd of any scoreboard entry with we=1, including WB, since the register file does not forward write to read.
- Scoreboard shift, when not frozen: WB<=MEM, MEM<=EXEC, EXEC<=DEC entry, or a bubble (we=0) when flush_exec_o=1. When frozen, all entries hold.
- FSM states:
  - RUN (2'd0): normal operation.
  - STALL (2'd1): RAW interlock.
  - MWAIT (2'd2): waiting on dmem_ready_i.
- Transitions and outputs, priority top-down:
  1. dmem_ready_i=0: go to MWAIT. stall_dec_o=1 and stall_exec_o=1. No flush and no fetch_nop. Scoreboard frozen.
  2. br_taken_i=1: go to RUN. flush_dec_o=1, flush_exec_o=1, fetch_nop_o=0. This overrides any RAW hazard, because DEC is wrong-path.
  3. raw_w=1: go to STALL. stall_dec_o=1, flush_exec_o=1, stall_exec_o=0.
  4. DEC holds JAL or JALR with no hazard: stay in RUN with fetch_nop_o=1.
  5. Otherwise: RUN, all controls 0.
- From MWAIT, when dmem_ready_i returns to 1, rules 2–5 are re-evaluated in the same cycle.
- From STALL, the FSM returns to RUN in the cycle raw_w drops.

## Timing
- Control outputs are combinational (Mealy) from the registered scoreboard, the FSM and the inputs. There are no combinational paths from clk edge to rd_add_o/reg_we_o.
- RAW stall length: 3 cycles when the producer is in EXEC, 2 when in MEM, 1 when in WB.
- Taken branch costs 2 bubbles. JAL/JALR costs 1 bubble via fetch_nop_o.
- Reset values: FSM=RUN, scoreboard all we=0/rd=0. Every output is 0 during and after reset until the first instruction decodes.
- Reset asserted mid-stall clears the FSM and scoreboard immediately.
- Simultaneous br_taken_i and dmem_ready_i=0: freeze wins. The branch is re-evaluated when ready returns, because EXEC is held.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments on every cycle with stall_dec_o=1.
  - flush_cnt_o increments on every cycle with flush_dec_o=1.
  - Both wrap at 2^32, reset to 0, and are not frozen by MWAIT.
- HAZARD_PERF_CNT_EN undefined: neither the ports nor the counters exist. Behaviour is otherwise identical.

## Test plan
- addi x5,x0,1 then add x6,x5,x5: stall_dec_o=1 for exactly 3 cycles and flush_exec_o=1 in each; x6=2 is written when reg_we_o=1 with rd_add_o=6.
- addi x0,x0,7 then add x6,x0,x0: no stall, because x0 is never a hazard.
- beq x0,x0,+8 reaching EXEC: flush_dec_o=flush_exec_o=1 for one cycle; the 2 following instructions produce no reg_we_o pulse.
- jal x1,+16 in DEC: fetch_nop_o=1 for one cycle; rd_add_o=1 with reg_we_o=1 three cycles later.
- dmem_ready_i held 0 for 4 cycles during lw x7,0(x0): stall_exec_o=stall_dec_o=1 for 4 cycles; the scoreboard is unchanged; hazard_state_o=2.
- resetn_i pulsed low while in STALL: all outputs go to 0 asynchronously, and hazard_state_o=0 on release.
